// File: rtl/garegga_prog_fifo.sv
// Download write buffer: merges byte-lane halves into masked 16-bit words, queues them in a
// small FIFO and feeds the SDRAM programming port with a hold-until-ready handshake.
module garegga_prog_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 22,
  parameter int unsigned FLUSH_CYCLES = 64
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_downloading,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_data,
  input  logic [1:0]    i_mask,
  input  logic [1:0]    i_ba,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_data,
  output logic [1:0]    o_mask,
  output logic [1:0]    o_ba,
  output logic          o_we,
  input  logic          i_rdy,
  output logic          o_busy,
  output logic          o_overflow,
  output logic [15:0]   o_words
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = AW + 20;
  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StGap} state_t;

  logic          r_pend_valid;
  logic [AW-1:0] r_pend_addr;
  logic [1:0]    r_pend_ba;
  logic [15:0]   r_pend_data;
  logic [1:0]    r_pend_mask;
  logic [CW-1:0] r_idle;
  logic          r_dl_q;
  logic          r_dl_fall;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW:0]   r_wr;
  logic [PW:0]   r_rd;
  logic          r_overflow;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_out_addr;
  logic [15:0]   r_out_data;
  logic [1:0]    r_out_mask;
  logic [1:0]    r_out_ba;
  logic [15:0]   r_words;

  logic          w_merge;
  logic          w_flush;
  logic          w_push;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [15:0]   w_merge_data;
  logic [EW-1:0] w_push_entry;
  logic [EW-1:0] w_head;

  // Merge only when both halves target the same word and write disjoint lanes.
  assign w_merge = r_pend_valid && (r_pend_addr == i_addr) && (r_pend_ba == i_ba) &&
                   ((r_pend_mask | i_mask) == 2'b11);
  assign w_merge_data = {i_mask[1] ? r_pend_data[15:8] : i_data,
                         i_mask[0] ? r_pend_data[7:0]  : i_data};
  assign w_flush = r_pend_valid && !i_we &&
                   ((r_idle == CW'(FLUSH_CYCLES - 1)) || r_dl_fall);

  always_comb begin
    w_push       = 1'b0;
    w_push_entry = {r_pend_addr, r_pend_ba, r_pend_data, r_pend_mask};
    if (i_we && r_pend_valid) begin
      w_push = 1'b1;
      if (w_merge) begin
        w_push_entry = {r_pend_addr, r_pend_ba, w_merge_data, r_pend_mask & i_mask};
      end
    end else if (w_flush) begin
      w_push = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_ba    <= '0;
      r_pend_data  <= '0;
      r_pend_mask  <= 2'b11;
      r_idle       <= '0;
      r_dl_q       <= 1'b0;
      r_dl_fall    <= 1'b0;
    end else begin
      r_dl_q    <= i_downloading;
      r_dl_fall <= r_dl_q & ~i_downloading;
      if (i_we) begin
        r_idle <= '0;
        if (w_merge) begin
          r_pend_valid <= 1'b0;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_addr  <= i_addr;
          r_pend_ba    <= i_ba;
          r_pend_data  <= {2{i_data}};
          r_pend_mask  <= i_mask;
        end
      end else if (w_flush) begin
        r_pend_valid <= 1'b0;
        r_idle       <= '0;
      end else if (r_pend_valid) begin
        r_idle <= r_idle + CW'(1);
      end
    end
  end

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
  assign w_pop     = (r_state == StIdle) && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr[PW-1:0]] <= w_push_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + (PW+1)'(1);
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_next = StWait;
      StWait:  if (i_rdy) w_state_next = StGap;
      StGap:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_out_mask <= 2'b11;
      r_out_ba   <= '0;
      r_words    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        {r_out_addr, r_out_ba, r_out_data, r_out_mask} <= w_head;
      end
      if ((r_state == StWait) && i_rdy) begin
        r_words <= r_words + 16'd1;
      end
    end
  end

  assign o_addr     = r_out_addr;
  assign o_data     = r_out_data;
  assign o_mask     = r_out_mask;
  assign o_ba       = r_out_ba;
  assign o_we       = (r_state == StWait);
  assign o_busy     = r_pend_valid || !w_empty || (r_state != StIdle);
  assign o_overflow = r_overflow;
  assign o_words    = r_words;

endmodule

// File: tb/tb_garegga_prog_fifo.sv
// Scoreboard bench for garegga_prog_fifo: expected SDRAM words are queued as bytes are driven
// and compared on each rising OUT_WE.
module tb_garegga_prog_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 22;
  localparam int unsigned FLUSH = 64;

  typedef logic [AW+19:0] entry_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          downloading;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic [1:0]    mask;
  logic [1:0]    ba;
  logic [AW-1:0] o_addr;
  logic [15:0]   o_data;
  logic [1:0]    o_mask;
  logic [1:0]    o_ba;
  logic          o_we;
  logic          rdy;
  logic          busy;
  logic          overflow;
  logic [15:0]   words;

  entry_t exp_q[$];
  int     n_checks  = 0;
  int     n_errors  = 0;
  int     n_writes  = 0;
  bit     rdy_hold  = 1'b0;
  int     rdy_delay = 4;

  always #5 clk = ~clk;

  garegga_prog_fifo #(.DEPTH(DEPTH), .AW(AW), .FLUSH_CYCLES(FLUSH)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_downloading (downloading),
    .i_we          (we),
    .i_addr        (addr),
    .i_data        (data),
    .i_mask        (mask),
    .i_ba          (ba),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .o_mask        (o_mask),
    .o_ba          (o_ba),
    .o_we          (o_we),
    .i_rdy         (rdy),
    .o_busy        (busy),
    .o_overflow    (overflow),
    .o_words       (words)
  );

  // SDRAM model: acknowledges a held write rdy_delay cycles after it appears.
  initial begin
    rdy = 1'b0;
    forever begin
      @(negedge clk);
      rdy = 1'b0;
      if (o_we && !rdy_hold) begin
        for (int k = 1; k < rdy_delay && o_we; k++) @(negedge clk);
        if (o_we && !rdy_hold) rdy = 1'b1;
      end
    end
  end

  // Scoreboard: every new write request must match the oldest expected word.
  initial begin
    logic   prev_we;
    entry_t got;
    entry_t exp;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (o_we && !prev_we) begin
        n_writes++;
        n_checks++;
        got = {o_addr, o_ba, o_data, o_mask};
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write got=%h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_errors++;
            $display("FAIL write_content got=%h expected=%h", got, exp);
          end
        end
      end
      prev_we = o_we;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge; leaves the byte strobe asserted for exactly the next posedge.
  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m,
                           input logic [1:0] b);
    we = 1'b1; addr = a; data = d; mask = m; ba = b;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_we(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (o_we) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({o_we, o_addr, o_data, o_mask, o_ba} !== {1'b0, 22'd0, 16'd0, 2'b11, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h mask=%b ba=%h", o_we, o_addr,
               o_data, o_mask, o_ba);
    end
    n_checks++;
    if ({busy, overflow, words} !== {1'b0, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_status got busy=%b ovf=%b words=%0d expected 0/0/0", busy, overflow,
               words);
    end
  endtask

  task automatic test_merge();
    bit ok;
    apply_reset();
    exp_q.push_back({22'h100, 2'd0, 16'h55AA, 2'b00});
    send_byte(22'h100, 8'hAA, 2'b10, 2'd0);
    send_byte(22'h100, 8'h55, 2'b01, 2'd0);
    wait_idle(200, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL merge_idle busy still high after 200 cycles");
    end
    n_checks++;
    if (words !== 16'd1 || n_writes !== 1) begin
      n_errors++;
      $display("FAIL merge_count got words=%0d writes=%0d expected 1/1", words, n_writes);
    end
  endtask

  task automatic test_idle_flush();
    int c;
    apply_reset();
    n_writes = 0;
    exp_q.push_back({22'h20, 2'd0, 16'h3C3C, 2'b10});
    send_byte(22'h20, 8'h3C, 2'b10, 2'd0);
    wait_we(200, c);
    n_checks++;
    if (c < 60 || c > 70) begin
      n_errors++;
      $display("FAIL idle_flush_latency got %0d cycles expected about %0d", c, FLUSH);
    end
  endtask

  task automatic test_dl_flush();
    int  c;
    bit  ok;
    apply_reset();
    n_writes = 0;
    exp_q.push_back({22'h20, 2'd0, 16'h3C3C, 2'b10});
    send_byte(22'h20, 8'h3C, 2'b10, 2'd0);
    repeat (4) @(negedge clk);
    downloading = 1'b0;
    wait_we(200, c);
    n_checks++;
    if (c < 1 || c + 5 > 12) begin
      n_errors++;
      $display("FAIL dl_flush_latency got %0d cycles after drop expected at most 7", c);
    end
    wait_idle(100, ok);
    downloading = 1'b1;
    n_checks++;
    if (!ok || words !== 16'd1) begin
      n_errors++;
      $display("FAIL dl_flush_done got idle=%b words=%0d expected 1/1", ok, words);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    n_writes = 0;
    rdy_hold = 1'b1;
    // With the SDRAM stalled, one word sits in the output stage and DEPTH wait in the FIFO.
    for (int i = 0; i < 20; i++) begin
      if (i <= DEPTH) begin
        exp_q.push_back({22'h200 + 22'(i), 2'd2, 8'(2 * i + 1), 8'(2 * i), 2'b00});
      end
      send_byte(22'h200 + 22'(i), 8'(2 * i), 2'b10, 2'd2);
      we = 1'b1;
      send_byte(22'h200 + 22'(i), 8'(2 * i + 1), 2'b01, 2'd2);
      if (i < 19) we = 1'b1;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1 || o_we !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_flag got ovf=%b we=%b expected 1/1", overflow, o_we);
    end
    rdy_hold = 1'b0;
    wait_idle(1000, ok);
    n_checks++;
    if (!ok || words !== 16'(DEPTH + 1) || n_writes !== DEPTH + 1) begin
      n_errors++;
      $display("FAIL overflow_drain got idle=%b words=%0d writes=%0d expected %0d", ok, words,
               n_writes, DEPTH + 1);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_sticky got %b expected 1", overflow);
    end
  endtask

  task automatic test_no_merge();
    bit ok;
    apply_reset();
    n_writes = 0;
    exp_q.push_back({22'h10, 2'd1, 16'h1111, 2'b10});
    exp_q.push_back({22'h10, 2'd0, 16'h2222, 2'b01});
    exp_q.push_back({22'h30, 2'd0, 16'h0101, 2'b10});
    exp_q.push_back({22'h30, 2'd0, 16'h0202, 2'b10});
    send_byte(22'h10, 8'h11, 2'b10, 2'd1);
    send_byte(22'h10, 8'h22, 2'b01, 2'd0);
    send_byte(22'h30, 8'h01, 2'b10, 2'd0);
    send_byte(22'h30, 8'h02, 2'b10, 2'd0);
    downloading = 1'b0;
    wait_idle(300, ok);
    downloading = 1'b1;
    n_checks++;
    if (!ok || words !== 16'd4 || n_writes !== 4) begin
      n_errors++;
      $display("FAIL no_merge_count got idle=%b words=%0d writes=%0d expected 4", ok, words,
               n_writes);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    apply_reset();
    n_writes = 0;
    rdy_hold = 1'b1;
    exp_q.push_back({22'h44, 2'd3, 16'h9999, 2'b01});
    send_byte(22'h44, 8'h99, 2'b01, 2'd3);
    downloading = 1'b0;
    wait_we(50, c);
    downloading = 1'b1;
    n_checks++;
    if (o_we !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_setup got we=%b expected 1", o_we);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_we, o_addr, o_data, o_mask, o_ba, busy, words} !==
        {1'b0, 22'd0, 16'd0, 2'b11, 2'd0, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_async got we=%b addr=%h data=%h mask=%b ba=%h busy=%b",
               o_we, o_addr, o_data, o_mask, o_ba, busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rdy_hold = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (o_we !== 1'b0 || busy !== 1'b0 || n_writes !== 1) begin
      n_errors++;
      $display("FAIL reset_mid_quiet got we=%b busy=%b writes=%0d expected 0/0/1", o_we, busy,
               n_writes);
    end
  endtask

  initial begin
    reset_n = 1'b0; downloading = 1'b1; we = 1'b0;
    addr = '0; data = '0; mask = 2'b11; ba = '0;
    test_reset();
    test_merge();
    test_idle_flush();
    test_dl_flush();
    test_overflow();
    test_no_merge();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
